// File: rtl/periph_uart_pkg.sv
// Shared constants, register map and FSM encoding for the UART transmitter peripheral.
package periph_uart_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIV_W  = 16;

    localparam logic [ADDR_W-1:0] UART_TXDATA_OFS  = 4'h0;
    localparam logic [ADDR_W-1:0] UART_STATUS_OFS  = 4'h4;
    localparam logic [ADDR_W-1:0] UART_BAUDDIV_OFS = 4'h8;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_EMPTY_BIT = 2;
    localparam int unsigned STAT_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // A divisor of zero would make the bit counter wrap, so it is stored as one.
    function automatic logic [DIV_W-1:0] div_sanitize(input logic [DIV_W-1:0] v);
        return (v == '0) ? DIV_W'(1) : v;
    endfunction

endpackage

// File: rtl/periph_uart_tx_if.sv
// Peripheral store/load bus between the data-memory decoder and the UART.
interface periph_uart_tx_if;
    import periph_uart_pkg::*;

    logic [ADDR_W-1:0] per_addr_i;
    logic [DATA_W-1:0] per_wdata_i;
    logic              per_we_i;
    logic [DATA_W-1:0] per_rdata_o;

    modport master (output per_addr_i, output per_wdata_i, output per_we_i, input per_rdata_o);
    modport slave  (input per_addr_i, input per_wdata_i, input per_we_i, output per_rdata_o);
endinterface

// File: rtl/periph_uart_tx_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/periph_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter and frame FSM.
module periph_uart_tx
    import periph_uart_pkg::*;
#(
    parameter int unsigned      FIFO_DEPTH = 8,
    parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    periph_uart_tx_if.slave bus,
    output logic            tx_o,
    output logic            irq_o
);
    localparam logic [1:0] ST_IDLE  = UART_IDLE;
    localparam logic [1:0] ST_START = UART_START;
    localparam logic [1:0] ST_DATA  = UART_DATA;
    localparam logic [1:0] ST_STOP  = UART_STOP;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] fdiv_q, fdiv_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             ovf_q, ovf_d;
    logic             tx_q, tx_d;
    logic             irq_q, irq_d;

    logic             wr_ok_c, wr_tx_c, wr_stat_c, wr_div_c;
    logic             fifo_push_c, fifo_pop_c, fifo_full_c, fifo_empty_c;
    logic [7:0]       fifo_rdata_c;
    logic             start_frame_c;
    logic [3:0]       status_c;
    logic [DATA_W-1:0] rdata_c;
    logic             unused_wdata_c;

    assign unused_wdata_c = ^bus.per_wdata_i[DATA_W-1:DIV_W];

    // Misaligned stores are dropped; byte/halfword stores to TXDATA still carry data in [7:0].
    always_comb begin
        wr_ok_c   = bus.per_we_i && (bus.per_addr_i[1:0] == 2'b00);
        wr_tx_c   = wr_ok_c && (bus.per_addr_i == UART_TXDATA_OFS);
        wr_stat_c = wr_ok_c && (bus.per_addr_i == UART_STATUS_OFS);
        wr_div_c  = wr_ok_c && (bus.per_addr_i == UART_BAUDDIV_OFS);
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push_c),
        .pop_i   (fifo_pop_c),
        .wdata_i (bus.per_wdata_i[7:0]),
        .rdata_c (fifo_rdata_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    // Register updates; a same-cycle pop frees the slot for a push to a full FIFO.
    always_comb begin
        div_d       = div_q;
        ovf_d       = ovf_q;
        fifo_push_c = wr_tx_c && (!fifo_full_c || fifo_pop_c);
        if (wr_div_c) div_d = div_sanitize(bus.per_wdata_i[DIV_W-1:0]);
        if (wr_stat_c && bus.per_wdata_i[STAT_OVF_BIT]) ovf_d = 1'b0;
        if (wr_tx_c && fifo_full_c && !fifo_pop_c) ovf_d = 1'b1;
    end

    always_comb begin
        status_c                 = '0;
        status_c[STAT_BUSY_BIT]  = (state_q != ST_IDLE);
        status_c[STAT_FULL_BIT]  = fifo_full_c;
        status_c[STAT_EMPTY_BIT] = fifo_empty_c;
        status_c[STAT_OVF_BIT]   = ovf_q;
        case (bus.per_addr_i)
            UART_STATUS_OFS:  rdata_c = DATA_W'(status_c);
            UART_BAUDDIV_OFS: rdata_c = DATA_W'(div_q);
            default:          rdata_c = '0;
        endcase
    end

    assign bus.per_rdata_o = rdata_c;

    // Frame FSM; the divisor is latched per frame so mid-frame BAUDDIV writes wait.
    always_comb begin
        state_d       = state_q;
        fdiv_d        = fdiv_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        fifo_pop_c    = 1'b0;
        start_frame_c = 1'b0;
        irq_d         = fifo_empty_c && (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: start_frame_c = !fifo_empty_c;
            ST_START: begin
                if (baud_q == '0) begin
                    state_d = ST_DATA;
                    baud_d  = fdiv_q - DIV_W'(1);
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = fdiv_q - DIV_W'(1);
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    if (!fifo_empty_c) begin
                        start_frame_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        if (start_frame_c) begin
            fifo_pop_c = 1'b1;
            shift_d    = fifo_rdata_c;
            fdiv_d     = div_q;
            baud_d     = div_q - DIV_W'(1);
            state_d    = ST_START;
            tx_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_RESET;
            fdiv_q  <= DIV_RESET;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            fdiv_q  <= fdiv_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_q;

endmodule

// File: tb/tb_periph_uart_tx.sv
// Directed bench for periph_uart_tx: bus writes/reads plus a serial-line scoreboard.
module tb_periph_uart_tx;
    import periph_uart_pkg::*;

    typedef struct {
        logic [7:0]  data;
        int unsigned div;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx, irq;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    exp_t        exp_q[$];
    int unsigned start_q[$];
    logic        mon_busy = 1'b0;
    exp_t        mon_e;
    logic [9:0]  mon_lv;
    bit          mon_abort;
    int unsigned c0;
    int unsigned n;

    periph_uart_tx_if bus();

    periph_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus),
        .tx_o    (tx),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.per_addr_i  = a;
        bus.per_wdata_i = d;
        bus.per_we_i    = 1'b1;
        @(negedge clk);
        bus.per_we_i    = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string tag);
        bus.per_addr_i = a;
        #1;
        chk(bus.per_rdata_o, e, tag);
    endtask

    task automatic push_byte(input logic [7:0] b, input int unsigned div);
        exp_q.push_back('{data: b, div: div});
        wr(UART_TXDATA_OFS, {24'h0, b});
    endtask

    task automatic wait_done(input int unsigned budget, input string tag);
        int unsigned k = 0;
        while (!(irq === 1'b1 && mon_busy === 1'b0 && exp_q.size() == 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(32'(k < budget), 32'd1, tag);
    endtask

    // Serial monitor: each frame popped from the scoreboard is checked level by level, cycle by cycle.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk(32'(tx), 32'd1, "unexpected_frame");
                end else begin
                    mon_e     = exp_q.pop_front();
                    mon_lv    = {1'b1, mon_e.data, 1'b0};
                    mon_abort = 1'b0;
                    for (int b = 0; b < 10 && !mon_abort; b++) begin
                        for (int c = 0; c < int'(mon_e.div) && !mon_abort; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst_n !== 1'b1) mon_abort = 1'b1;
                            else chk(32'(tx), 32'(mon_lv[b]),
                                     $sformatf("tx_%02h_lvl%0d_cyc%0d", mon_e.data, b, c));
                        end
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bus.per_addr_i  = '0;
        bus.per_wdata_i = '0;
        bus.per_we_i    = 1'b0;
        repeat (3) @(negedge clk);
        chk(32'(tx), 32'd1, "rst_tx");
        chk(32'(irq), 32'd1, "rst_irq");
        rst_n = 1'b1;
        @(negedge clk);
        rd(UART_STATUS_OFS, 32'h4, "rst_status");
        rd(UART_BAUDDIV_OFS, 32'd434, "rst_div");
        rd(4'hC, 32'h0, "rsvd_read");
        rd(UART_TXDATA_OFS, 32'h0, "txdata_read");

        // 0x55 at DIV=4: alternating 4-cycle levels and exact irq timing
        wr(UART_BAUDDIV_OFS, 32'd4);
        rd(UART_BAUDDIV_OFS, 32'd4, "div_rd4");
        start_q.delete();
        push_byte(8'h55, 4);
        chk(32'(irq), 32'd1, "irq_at_push");
        @(negedge clk);
        chk(32'(irq), 32'd0, "irq_deassert");
        chk(32'(tx), 32'd0, "tx_fall_latency");
        repeat (40) @(negedge clk);
        chk(32'(tx), 32'd1, "tx_idle_after");
        chk(32'(irq), 32'd0, "irq_stop_edge");
        @(negedge clk);
        chk(32'(irq), 32'd1, "irq_reassert");
        chk(32'(start_q.size()), 32'd1, "frame_count_55");

        // Misaligned byte store is ignored
        wr(4'h1, 32'h0000_A500);
        rd(UART_STATUS_OFS, 32'h4, "sb_ignored_status");
        repeat (20) @(negedge clk);
        chk(32'(tx), 32'd1, "sb_tx_idle");

        // Burst of 9 at DIV=2, 10th overflows, then sticky clear
        wr(UART_BAUDDIV_OFS, 32'd2);
        start_q.delete();
        for (int i = 0; i < 9; i++) begin
            push_byte(8'(8'hA0 + 8'(i) * 8'h13), 2);
            if (i == 0) c0 = cyc;
        end
        wr(UART_TXDATA_OFS, 32'h0000_00EE);
        rd(UART_STATUS_OFS, 32'hB, "ovf_set_status");
        wr(UART_STATUS_OFS, 32'h8);
        rd(UART_STATUS_OFS, 32'h3, "ovf_clr_status");
        wait_done(400, "burst_done");
        chk(32'(start_q.size()), 32'd9, "burst_frames");
        if (start_q.size() == 9) begin
            chk(start_q[0], c0 + 1, "burst_first_pop");
            chk(start_q[8] - start_q[0], 32'd160, "burst_back_to_back");
        end

        // Zero divisor stored as 1: 10-cycle frames
        wr(UART_BAUDDIV_OFS, 32'd0);
        rd(UART_BAUDDIV_OFS, 32'd1, "div_zero_rd");
        start_q.delete();
        push_byte(8'h3C, 1);
        wait_done(100, "div1_done");
        chk(32'(start_q.size()), 32'd1, "div1_frames");

        // Divisor change mid-frame applies to the next frame only
        wr(UART_BAUDDIV_OFS, 32'd4);
        start_q.delete();
        push_byte(8'hC3, 4);
        push_byte(8'h96, 8);
        repeat (10) @(negedge clk);
        wr(UART_BAUDDIV_OFS, 32'd8);
        wait_done(300, "divchg_done");
        chk(32'(start_q.size()), 32'd2, "divchg_frames");
        if (start_q.size() == 2) chk(start_q[1] - start_q[0], 32'd40, "divchg_frame1_len");

        // Reset during data bit 3 aborts the frame and flushes state
        wr(UART_BAUDDIV_OFS, 32'd4);
        start_q.delete();
        push_byte(8'h5A, 4);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(32'(n < 20), 32'd1, "rst_test_frame_start");
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(32'(tx), 32'd1, "midframe_rst_tx");
        chk(32'(irq), 32'd1, "midframe_rst_irq");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(UART_STATUS_OFS, 32'h4, "post_rst_status");
        rd(UART_BAUDDIV_OFS, 32'd434, "post_rst_div");
        start_q.delete();
        repeat (60) @(negedge clk);
        chk(32'(tx), 32'd1, "post_rst_tx_idle");
        chk(32'(start_q.size()), 32'd0, "no_residual_frame");
        chk(32'(exp_q.size()), 32'd0, "scoreboard_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
